// File: rtl/common.sv
// Bus request/response types shared by the pipeline's memory ports and the downstream bus.
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-local definitions used by the memory bus arbiter.
package pipes;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

  localparam common::msize_t MSIZE4 = common::MSIZE4;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick between the fetch and data ports.
// MEM_ARB_ROUND_ROBIN_EN alternates on contention; otherwise the data port always wins.
module mem_arb_select (
  input  logic ivalid,
  input  logic dvalid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_d,
`endif
  output logic sel_d,
  output logic sel_any
);

  always_comb begin
    sel_any = ivalid | dvalid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the port that did not complete last goes next.
    sel_d = dvalid & (~ivalid | ~last_d);
`else
    sel_d = dvalid;
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory bus between the fetch and data ports of the pipeline.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces fixed data-port priority with alternation.
module mem_bus_arbiter
  import pipes::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  common::ibus_req_t  ireq,
  output common::ibus_resp_t iresp,
  input  common::dbus_req_t  dreq,
  output common::dbus_resp_t dresp,
  output common::dbus_req_t  oreq,
  input  common::dbus_resp_t oresp,
  output logic               busy,
  output arb_state_t         state
);

  localparam int STRB_W = DATA_W / 8;

  // Handshake: a requester holds valid and fields stable until its data_ok;
  // valid still high in the cycle after data_ok is a fresh request.
  arb_state_t        next_state;
  common::dbus_req_t hold;
  logic              sel_d;
  logic              sel_any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (busy && oresp.data_ok) begin
      last_d <= (state == GRANT_D);
    end
  end
`endif

  mem_arb_select u_select (
    .ivalid  (ireq.valid),
    .dvalid  (dreq.valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_d  (last_d),
`endif
    .sel_d   (sel_d),
    .sel_any (sel_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && sel_any) begin
        // A fetch is issued downstream as a plain 4-byte read.
        if (sel_d) begin
          hold <= dreq;
        end else begin
          hold <= '{valid:  1'b1,
                    addr:   ADDR_W'(ireq.addr),
                    size:   MSIZE4,
                    strobe: STRB_W'(0),
                    data:   DATA_W'(0)};
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    oreq       = '0;
    iresp      = '0;
    dresp      = '0;
    case (state)
      IDLE: begin
        if (sel_any) next_state = sel_d ? GRANT_D : GRANT_I;
      end
      GRANT_D: begin
        busy  = 1'b1;
        oreq  = hold;
        dresp = oresp;
        if (oresp.data_ok) next_state = IDLE;
      end
      GRANT_I: begin
        busy          = 1'b1;
        oreq          = hold;
        iresp.addr_ok = oresp.addr_ok;
        iresp.data_ok = oresp.data_ok;
        iresp.data    = hold.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
        if (oresp.data_ok) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter; honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_bus_arbiter;
  import common::*;

  logic               clk = 1'b0;
  logic               reset;
  ibus_req_t          ireq;
  ibus_resp_t         iresp;
  dbus_req_t          dreq;
  dbus_resp_t         dresp;
  dbus_req_t          oreq;
  dbus_resp_t         oresp;
  logic               busy;
  pipes::arb_state_t  state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // Reference model of the bus owner: 0 none, 1 data port, 2 fetch port.
  int         owner;
  dbus_req_t  g;
  bit         fresh;
  int         lat;
  bit         last_dm;
  bit         i_done;
  bit         d_done;
  bit         pick_d;
  pipes::arb_state_t exp_state;
  dbus_req_t  exp_o;
  ibus_resp_t exp_i;
  dbus_resp_t exp_d;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .oreq  (oreq),
    .oresp (oresp),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_dreq();
    dreq.valid  = 1'b1;
    dreq.addr   = {$urandom, $urandom};
    dreq.size   = msize_t'($urandom_range(0, 3));
    dreq.strobe = 8'($urandom);
    dreq.data   = {$urandom, $urandom};
  endtask

  task automatic new_ireq();
    ireq.valid = 1'b1;
    ireq.addr  = {$urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sample();
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_oreq", 256'(oreq), 256'(0));
    check("reset_iresp", 256'(iresp), 256'(0));
    check("reset_dresp", 256'(dresp), 256'(0));
    check("reset_state", 256'(state), 256'(pipes::IDLE));

    // Single fetch from an odd word: upper half of the bus data returns.
    step();
    ireq = '{valid: 1'b1, addr: 64'h8000_0004};
    step();
    sample();
    exp_o = '{valid: 1'b1, addr: 64'h8000_0004, size: MSIZE4, strobe: 8'h00, data: 64'h0};
    check("fetch_oreq", 256'(oreq), 256'(exp_o));
    check("fetch_busy", 256'(busy), 256'(1));
    check("fetch_wait_iresp", 256'(iresp), 256'(0));
    step();
    sample();
    check("fetch_wait2_iresp", 256'(iresp.data_ok), 256'(0));
    step();
    oresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 64'h1111_2222_3333_4444};
    sample();
    exp_i = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h1111_2222};
    check("fetch_iresp", 256'(iresp), 256'(exp_i));
    check("fetch_dresp", 256'(dresp), 256'(0));
    step();
    ireq  = '0;
    oresp = '0;
    sample();
    check("fetch_done_busy", 256'(busy), 256'(0));
    check("fetch_done_state", 256'(state), 256'(pipes::IDLE));

    // Collision: store wins, fetch follows after one idle cycle.
    step();
    ireq = '{valid: 1'b1, addr: 64'h8000_0000};
    dreq = '{valid: 1'b1, addr: 64'h8001_0000, size: MSIZE8, strobe: 8'hFF, data: 64'hDEAD};
    step();
    sample();
    check("coll_state_d", 256'(state), 256'(pipes::GRANT_D));
    exp_o = '{valid: 1'b1, addr: 64'h8001_0000, size: MSIZE8, strobe: 8'hFF, data: 64'hDEAD};
    check("coll_oreq_d", 256'(oreq), 256'(exp_o));
    step();
    dreq.addr = 64'h1234;
    sample();
    check("hold_addr", 256'(oreq.addr), 256'(64'h8001_0000));
    step();
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hCAFE};
    sample();
    check("hold_addr_at_ok", 256'(oreq.addr), 256'(64'h8001_0000));
    exp_d = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hCAFE};
    check("coll_dresp", 256'(dresp), 256'(exp_d));
    check("coll_iresp_quiet", 256'(iresp), 256'(0));
    step();
    dreq  = '0;
    oresp = '0;
    sample();
    check("coll_gap_state", 256'(state), 256'(pipes::IDLE));
    check("coll_gap_oreq", 256'(oreq), 256'(0));
    step();
    sample();
    check("coll_state_i", 256'(state), 256'(pipes::GRANT_I));
    check("coll_oreq_i_addr", 256'(oreq.addr), 256'(64'h8000_0000));
    step();
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hAAAA_BBBB_CCCC_DDDD};
    sample();
    exp_i = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hCCCC_DDDD};
    check("coll_iresp", 256'(iresp), 256'(exp_i));
    check("coll_dresp_quiet", 256'(dresp), 256'(0));
    step();
    ireq  = '0;
    oresp = '0;

    // Reset in the middle of a fetch grant, then a late data_ok.
    step();
    ireq = '{valid: 1'b1, addr: 64'h8000_0008};
    step();
    sample();
    check("rst_mid_state", 256'(state), 256'(pipes::GRANT_I));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ireq  = '0;
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hFFFF_FFFF_FFFF_FFFF};
    sample();
    check("rst_mid_busy", 256'(busy), 256'(0));
    check("rst_mid_oreq", 256'(oreq), 256'(0));
    check("rst_mid_iresp", 256'(iresp), 256'(0));
    check("rst_mid_dresp", 256'(dresp), 256'(0));
    step();
    oresp = '0;
    sample();
    check("rst_mid_after", 256'(state), 256'(pipes::IDLE));

    // Stale data_ok while idle.
    step();
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h5555_6666_7777_8888};
    sample();
    check("stale_iresp", 256'(iresp), 256'(0));
    check("stale_dresp", 256'(dresp), 256'(0));
    step();
    oresp = '0;
    sample();
    check("stale_state", 256'(state), 256'(pipes::IDLE));
    check("stale_busy", 256'(busy), 256'(0));

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Both ports stay valid: grants alternate starting with the data port.
    step();
    ireq = '{valid: 1'b1, addr: 64'h100};
    dreq = '{valid: 1'b1, addr: 64'h200, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    for (int k = 0; k < 4; k++) begin
      step();
      sample();
      check("rr_order", 256'(state), 256'((k % 2 == 0) ? pipes::GRANT_D : pipes::GRANT_I));
      step();
      oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
      step();
      oresp = '0;
    end
    ireq = '0;
    dreq = '0;
`endif

    // Randomized traffic against the transaction-level model.
    step();
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    reset = 1'b1;
    step();
    step();
    reset   = 1'b0;
    owner   = 0;
    last_dm = 1'b0;
    fresh   = 1'b0;
    lat     = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      i_done = 1'b0;
      d_done = 1'b0;
      if (owner != 0 && oresp.data_ok) begin
        if (owner == 1) begin
          d_done  = 1'b1;
          last_dm = 1'b1;
        end else begin
          i_done  = 1'b1;
          last_dm = 1'b0;
        end
        owner = 0;
      end else if (owner == 0 && (ireq.valid || dreq.valid)) begin
        pick_d = dreq.valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (dreq.valid && ireq.valid) pick_d = !last_dm;
`endif
        if (pick_d) begin
          owner = 1;
          g     = dreq;
        end else begin
          owner = 2;
          g     = '{valid: 1'b1, addr: ireq.addr, size: MSIZE4, strobe: 8'h00, data: 64'h0};
        end
        exp_q.push_back(g.addr);
        fresh = 1'b1;
        lat   = $urandom_range(0, 3);
      end
      if (d_done) dreq.valid = 1'b0;
      if (i_done) ireq.valid = 1'b0;
      if (!dreq.valid && $urandom_range(0, 2) != 0) new_dreq();
      if (!ireq.valid && $urandom_range(0, 2) != 0) new_ireq();
      oresp.addr_ok = 1'($urandom);
      oresp.data    = {$urandom, $urandom};
      if (owner != 0) begin
        if (lat == 0) begin
          oresp.data_ok = 1'b1;
        end else begin
          oresp.data_ok = 1'b0;
          lat--;
        end
      end else begin
        oresp.data_ok = ($urandom_range(0, 5) == 0);
      end

      sample();
      exp_state = (owner == 0) ? pipes::IDLE : (owner == 1) ? pipes::GRANT_D : pipes::GRANT_I;
      check("rnd_state", 256'(state), 256'(exp_state));
      check("rnd_busy", 256'(busy), 256'(owner != 0));
      if (fresh) begin
        check("rnd_grant_addr", 256'(oreq.addr), 256'(exp_q.pop_front()));
        fresh = 1'b0;
      end
      exp_o = (owner != 0) ? g : '0;
      check("rnd_oreq", 256'(oreq), 256'(exp_o));
      exp_i = '0;
      exp_d = '0;
      if (owner == 1) begin
        exp_d = oresp;
      end else if (owner == 2) begin
        exp_i.addr_ok = oresp.addr_ok;
        exp_i.data_ok = oresp.data_ok;
        exp_i.data    = g.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
      end
      check("rnd_iresp", 256'(iresp), 256'(exp_i));
      check("rnd_dresp", 256'(dresp), 256'(exp_d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
